// File: rtl/booth_radix4_mult_if.sv
// Operand/handshake/result bundle for the radix-4 Booth multiplier.
// The master drives the request side, the slave (the multiplier) answers
// with busy/done and the product.
interface booth_radix4_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_op;
   logic [WIDTH-1:0]     multiplier;
   logic [WIDTH-1:0]     multiplicand;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_op, multiplier, multiplicand,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_op, multiplier, multiplicand,
      output busy, done, product
   );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier.
// Operands are extended to an even width EXT (one guard bit above WIDTH so
// unsigned operands become non-negative signed values), then ITER = EXT/2
// Booth steps each retire two multiplier bits. The low 2*WIDTH bits of the
// {A,Q} result are the exact product in either signed or unsigned mode.
// A zero operand skips the iterations and finishes on the next cycle.
module booth_radix4_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,   // active-low, asynchronous assert
   booth_radix4_mult_if.slave bus
);
   localparam int EXT  = ((WIDTH + 1) % 2 == 0) ? (WIDTH + 1) : (WIDTH + 2);
   localparam int ITER = EXT / 2;
   localparam int AW   = EXT + 2;               // accumulator width
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [AW-1:0]        acc_reg, acc_next;
   logic [AW-1:0]        m_reg, m_next;
   logic [EXT-1:0]       q_reg, q_next;
   logic                 q_m1_reg, q_m1_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [2*WIDTH-1:0]   product_reg, product_next;

   // Extended operands presented at acceptance time
   logic [EXT-1:0]       q_ext;
   logic [AW-1:0]        m_ext;
   logic                 zero_op;

   // One Booth step worth of datapath
   logic [AW-1:0]        m_x2;
   logic [AW-1:0]        addend;
   logic [AW-1:0]        sum;
   logic [AW-1:0]        acc_sh;
   logic [EXT-1:0]       q_sh;
   logic                 q_m1_sh;

   // Sign- or zero-extend the incoming operands according to signed_op
   always_comb begin
      q_ext   = {{(EXT-WIDTH){bus.signed_op & bus.multiplier[WIDTH-1]}}, bus.multiplier};
      m_ext   = {{(AW-WIDTH){bus.signed_op & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      zero_op = (bus.multiplier == '0) || (bus.multiplicand == '0);
   end

   // Booth recoding of {q[1],q[0],q[-1]}, add, then arithmetic shift by two
   always_comb begin
      m_x2 = {m_reg[AW-2:0], 1'b0};
      case ({q_reg[1:0], q_m1_reg})
         3'b001, 3'b010: addend = m_reg;
         3'b011:         addend = m_x2;
         3'b100:         addend = ~m_x2 + {{(AW-1){1'b0}}, 1'b1};
         3'b101, 3'b110: addend = ~m_reg + {{(AW-1){1'b0}}, 1'b1};
         default:        addend = '0;
      endcase
      sum     = acc_reg + addend;
      acc_sh  = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_sh    = {sum[1:0], q_reg[EXT-1:2]};
      q_m1_sh = q_reg[1];
   end

   // Next-state and datapath update; everything holds unless a state acts
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      m_next       = m_reg;
      q_next       = q_reg;
      q_m1_next    = q_m1_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               q_next    = q_ext;
               m_next    = m_ext;
               acc_next  = '0;
               q_m1_next = 1'b0;
               cnt_next  = '0;
               if (zero_op) begin
                  product_next = '0;
                  state_next   = DONE;
               end else begin
                  state_next   = RUN;
               end
            end
         end
         RUN: begin
            acc_next  = acc_sh;
            q_next    = q_sh;
            q_m1_next = q_m1_sh;
            cnt_next  = cnt_reg + CW'(1);
            if (cnt_reg == CW'(ITER - 1)) begin
               // Result is loaded on the edge entering DONE so it is valid with done
               product_next = (2*WIDTH)'({acc_sh, q_sh});
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_reg     <= '0;
         m_reg       <= '0;
         q_reg       <= '0;
         q_m1_reg    <= 1'b0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         acc_reg     <= acc_next;
         m_reg       <= m_next;
         q_reg       <= q_next;
         q_m1_reg    <= q_m1_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
      end
   end

   assign bus.busy    = (state_reg != IDLE);
   assign bus.done    = (state_reg == DONE);
   assign bus.product = product_reg;

endmodule
